// File: rtl/ctr_share_pkg.sv
// Shared definitions for the counter-sharing sequencer.
//   state_t     : sequencer FSM encoding (IDLE, RUN, DONE)
//   WIDTH_DEF   : default counter width
//   NREQ_DEF    : default number of requesters
//   len_to_mod  : maps a programmed length to a modulus (0 means 2^width)
package ctr_share_pkg;

    localparam int WIDTH_DEF = 3;
    localparam int NREQ_DEF  = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // A length of zero cannot be a useful period, so it encodes the full
    // 2^width range that would otherwise need one extra bit on the input.
    function automatic int unsigned len_to_mod(input int unsigned len_v,
                                               input int unsigned width);
        return (len_v == 0) ? (32'd1 << width) : len_v;
    endfunction

endpackage

// File: rtl/ctr_share_seq_if.sv
// Requester-side bundle of the counter-sharing sequencer.
//   req   : per-requester request, held until its done pulse
//   len   : per-requester modulus, slice i = len[i*WIDTH +: WIDTH]
//   abort : terminate the running job
//   gnt   : one-hot grant while a job runs
//   busy  : sequencer in RUN or DONE
//   q     : shared counter value
//   tc    : terminal count in the last RUN cycle
//   done  : one-cycle completion pulse to the granted requester
// master = requester side, slave = sequencer side.
interface ctr_share_seq_if
    import ctr_share_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int NREQ  = NREQ_DEF
);
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] len;
    logic                  abort;
    logic [NREQ-1:0]       gnt;
    logic                  busy;
    logic [WIDTH-1:0]      q;
    logic                  tc;
    logic [NREQ-1:0]       done;

    modport master (output req, len, abort,
                    input  gnt, busy, q, tc, done);
    modport slave  (input  req, len, abort,
                    output gnt, busy, q, tc, done);
endinterface

// File: rtl/ctr_share_seq_rr_arb.sv
// Combinational round-robin winner select.
//   req : request vector
//   ptr : index searched first
//   win : one-hot winner
//   idx : winner index
//   any : at least one request present
module rr_arb
    import ctr_share_pkg::*;
#(
    parameter  int NREQ = NREQ_DEF,
    localparam int IDXW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] ptr,
    output logic [NREQ-1:0] win,
    output logic [IDXW-1:0] idx,
    output logic            any
);
    always_comb begin
        int c;
        win = '0;
        idx = '0;
        any = 1'b0;
        c   = 0;
        for (int k = 0; k < NREQ; k++) begin
            c = (int'(ptr) + k) % NREQ;
            if (!any && req[c]) begin
                any    = 1'b1;
                win[c] = 1'b1;
                idx    = IDXW'(c);
            end
        end
    end
endmodule

// File: rtl/ctr_share_seq.sv
// Sequencer/arbiter sharing one modulo-M up-counter among NREQ requesters.
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset
//   bus : ctr_share_seq_if slave (req/len/abort in, gnt/busy/q/tc/done out)
// Requesters are granted round-robin; each grant loads the modulus, runs
// q through 0..M-1 and returns a one-cycle done pulse (unless aborted).
module ctr_share_seq
    import ctr_share_pkg::*;
#(
    parameter  int WIDTH = WIDTH_DEF,
    parameter  int NREQ  = NREQ_DEF,
    localparam int IDXW  = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            rst,
    ctr_share_seq_if.slave  bus
);
    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH:0]   m_q, m_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [NREQ-1:0]  done_q, done_d;
    logic [IDXW-1:0]  w_q, w_d;
    logic [IDXW-1:0]  ptr_q, ptr_d;

    logic [NREQ-1:0]  arb_win;
    logic [IDXW-1:0]  arb_idx;
    logic             arb_any;
    logic [WIDTH-1:0] len_sel;
    logic [IDXW-1:0]  ptr_nxt;
    logic             tc_c;

    rr_arb #(.NREQ(NREQ)) u_arb (
        .req (bus.req),
        .ptr (ptr_q),
        .win (arb_win),
        .idx (arb_idx),
        .any (arb_any)
    );

    assign len_sel = bus.len[int'(arb_idx)*WIDTH +: WIDTH];

    // The pointer holds the index searched first, i.e. last winner + 1.
    // Resetting it to 0 gives req[0] top priority after reset.
    assign ptr_nxt = (w_q == IDXW'(NREQ-1)) ? '0 : w_q + IDXW'(1);

    // m_q is one bit wider than q so M = 2^WIDTH compares as q == all-ones.
    assign tc_c = (state_q == RUN) && ({1'b0, q_q} == m_q - (WIDTH+1)'(1));

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        m_d     = m_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        w_d     = w_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                q_d = '0;
                if (arb_any) begin
                    w_d     = arb_idx;
                    m_d     = (WIDTH+1)'(len_to_mod(32'(len_sel), WIDTH));
                    gnt_d   = arb_win;
                    state_d = RUN;
                end
            end
            RUN: begin
                // abort has priority over tc: an aborted job never reports done
                if (bus.abort) begin
                    state_d = IDLE;
                    q_d     = '0;
                    gnt_d   = '0;
                    ptr_d   = ptr_nxt;
                end else if (tc_c) begin
                    state_d = DONE;
                    q_d     = '0;
                    gnt_d   = '0;
                    done_d  = gnt_q;
                end else begin
                    q_d = q_q + WIDTH'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                ptr_d   = ptr_nxt;
            end
            default: begin
                state_d = IDLE;
                q_d     = '0;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            q_q     <= '0;
            m_q     <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            w_q     <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            m_q     <= m_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            w_q     <= w_d;
            ptr_q   <= ptr_d;
        end
    end

    assign bus.gnt  = gnt_q;
    assign bus.done = done_q;
    assign bus.busy = (state_q != IDLE);
    assign bus.q    = q_q;
    assign bus.tc   = tc_c;

endmodule

// File: tb/tb_ctr_share_seq.sv
// Directed bench for ctr_share_seq (WIDTH=3, NREQ=2).
module tb_ctr_share_seq;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    ctr_share_seq_if #(.WIDTH(3), .NREQ(2)) bus ();

    ctr_share_seq #(.WIDTH(3), .NREQ(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_gnt"},  32'(bus.gnt),  32'd0);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_q"},    32'(bus.q),    32'd0);
        chk({tag, "_tc"},   32'(bus.tc),   32'd0);
        chk({tag, "_done"}, 32'(bus.done), 32'd0);
    endtask

    // Called one sample after the granting edge; returns in the DONE cycle.
    task automatic run_job(input string tag, input logic [1:0] g, input int m);
        for (int i = 0; i < m; i++) begin
            chk({tag, "_q"},    32'(bus.q),    32'(i));
            chk({tag, "_gnt"},  32'(bus.gnt),  32'(g));
            chk({tag, "_tc"},   32'(bus.tc),   (i == m-1) ? 32'd1 : 32'd0);
            chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
            chk({tag, "_done"}, 32'(bus.done), 32'd0);
            step();
        end
        chk({tag, "_dn_done"}, 32'(bus.done), 32'(g));
        chk({tag, "_dn_gnt"},  32'(bus.gnt),  32'd0);
        chk({tag, "_dn_q"},    32'(bus.q),    32'd0);
        chk({tag, "_dn_busy"}, 32'(bus.busy), 32'd1);
        chk({tag, "_dn_tc"},   32'(bus.tc),   32'd0);
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        bus.req   = 2'b00;
        bus.len   = 6'd0;
        bus.abort = 1'b0;
        step();
        step();
        chk_idle("rst");
        rst = 1'b0;
        step();
        chk_idle("idle0");

        // single job, len0=6
        bus.len = {3'd0, 3'd6};
        bus.req = 2'b01;
        step();
        run_job("j6", 2'b01, 6);
        bus.req = 2'b00;
        step();
        chk_idle("j6_end");

        // both from reset: order 0 then 1
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.len = {3'd2, 3'd3};
        bus.req = 2'b11;
        step();
        run_job("both0", 2'b01, 3);
        bus.req = 2'b10;
        step();
        chk_idle("both_gap");
        step();
        run_job("both1", 2'b10, 2);
        bus.req = 2'b00;
        step();
        chk_idle("both_end");

        // both held: alternate 0,1,0,1 (pointer is back at 0)
        bus.len = {3'd1, 3'd2};
        bus.req = 2'b11;
        step();
        run_job("alt0", 2'b01, 2);
        step();
        chk_idle("alt_gap0");
        step();
        run_job("alt1", 2'b10, 1);
        step();
        step();
        run_job("alt2", 2'b01, 2);
        step();
        step();
        run_job("alt3", 2'b10, 1);
        bus.req = 2'b00;
        step();
        chk_idle("alt_end");

        // len0=0 -> modulus 8; len change during RUN has no effect
        bus.len = {3'd0, 3'd0};
        bus.req = 2'b01;
        step();
        bus.len = {3'd0, 3'd5};
        run_job("m8", 2'b01, 8);
        bus.req = 2'b00;
        step();
        // len0=1 -> single RUN cycle with tc
        bus.len = {3'd0, 3'd1};
        bus.req = 2'b01;
        step();
        run_job("m1", 2'b01, 1);
        bus.req = 2'b00;
        step();
        chk_idle("m1_end");

        // abort at q=2 of a len=6 job on requester 1 (pointer now 1)
        bus.len = {3'd6, 3'd2};
        bus.req = 2'b11;
        step();
        chk("ab_gnt", 32'(bus.gnt), 32'd2);
        step();
        step();
        chk("ab_q2", 32'(bus.q), 32'd2);
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        chk_idle("ab");
        // pointer advanced past 1, so requester 0 wins despite req1 still high
        step();
        run_job("ab_next", 2'b01, 2);
        bus.req = 2'b00;
        step();
        chk_idle("ab_next_end");

        // abort coinciding with tc: no done (pointer now 1, only req0 pending)
        bus.len = {3'd0, 3'd1};
        bus.req = 2'b01;
        step();
        chk("abtc_tc", 32'(bus.tc), 32'd1);
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        chk_idle("abtc");
        bus.req = 2'b00;
        step();
        chk_idle("abtc_idle");

        // async reset mid-RUN at q=4
        bus.len = {3'd0, 3'd6};
        bus.req = 2'b01;
        step();
        step();
        step();
        step();
        step();
        chk("rr_q4", 32'(bus.q), 32'd4);
        #2;
        rst = 1'b1;
        #1;
        chk_idle("async_rst");
        #2;
        rst = 1'b0;
        step();
        run_job("regrant", 2'b01, 6);
        bus.req = 2'b00;
        step();
        chk_idle("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
